// File: rtl/dt_input_pkg.sv
// dt_input_pkg: shared types and defaults for the front-panel
// button debounce / event arbiter slice.
package dt_input_pkg;

  localparam int DT_TICK_DIV_DEFAULT     = 50000;
  localparam int DT_STABLE_TICKS_DEFAULT = 4;
  localparam int DT_CHAN_W               = 4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [DT_CHAN_W-1:0] chan;
    logic                 press;
  } evt_t;

endpackage

// File: rtl/button_filter.sv
// button_filter: 2-flop synchronizer plus tick-sampled stability
// counter; edge_o strobes for one cycle as level_o flips.
module button_filter
  import dt_input_pkg::*;
#(
  parameter int STABLE_TICKS = DT_STABLE_TICKS_DEFAULT
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic edge_o
);

  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          edge_q, edge_d;

  // bring the raw pin into the clock domain
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) sync_q <= '0;
    else         sync_q <= {sync_q[0], raw_i};
  end

  // count consecutive differing ticks; flip level on the last one
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    edge_d  = 1'b0;
    if (tick_i) begin
      if (sync_q[1] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == LAST) begin
        cnt_d   = '0;
        level_d = ~level_q;
        edge_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // filter state registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  assign level_o = level_q;
  assign edge_o  = edge_q;

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounced buttons -> round-robin event stream.
// DT_RELEASE_EVENT_EN: release edges also produce events.
module button_event_arbiter
  import dt_input_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = DT_TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = DT_STABLE_TICKS_DEFAULT
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic [CHANNELS-1:0]         iButtons,
  output logic [CHANNELS-1:0]         oLevel,
  output logic                        oEvtValid,
  input  logic                        iEvtReady,
  output logic [$clog2(CHANNELS)-1:0] oEvtChan,
  output logic                        oEvtPress,
  output logic                        oDrop
);

  localparam int CW = $clog2(CHANNELS);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);

`ifdef DT_RELEASE_EVENT_EN
  localparam logic PRESS_RST = 1'b0;
`else
  localparam logic PRESS_RST = 1'b1;
`endif

  logic [PW-1:0]       ps_q, ps_d;
  logic                tick;
  logic [CHANNELS-1:0] edge_w, evt_w;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic                drop_q, drop_d;
  arb_state_e          state_q, state_d;
  evt_t                evt_q, evt_d;
  logic [CW-1:0]       rr_q, rr_d;
  logic [CW-1:0]       sel, cur_chan;
  logic                found, load;
  int                  idx;

  assign tick = (ps_q == PS_LAST);

  // sample tick prescaler
  always_comb begin
    ps_d = tick ? '0 : ps_q + PW'(1);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_filter #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_filt (
      .iClk   (iClk),
      .iRst_n (iRst_n),
      .tick_i (tick),
      .raw_i  (iButtons[i]),
      .level_o(oLevel[i]),
      .edge_o (edge_w[i])
    );
  end

`ifdef DT_RELEASE_EVENT_EN
  logic [CHANNELS-1:0] pol_q;
  assign evt_w = edge_w;

  // latest edge polarity per channel
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) pol_q <= '0;
    else         pol_q <= (pol_q & ~evt_w) | (oLevel & evt_w);
  end
`else
  assign evt_w = edge_w & oLevel;
`endif

  // first pending channel at or above rr_q, circularly
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (pend_q[idx]) begin
        sel   = CW'(idx);
        found = 1'b1;
      end
    end
  end

  assign cur_chan = CW'(evt_q.chan);

  // arbiter next state and event load
  always_comb begin
    state_d = state_q;
    evt_d   = evt_q;
    rr_d    = rr_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (found) begin
          load       = 1'b1;
          evt_d.chan = DT_CHAN_W'(sel);
`ifdef DT_RELEASE_EVENT_EN
          evt_d.press = pol_q[sel];
`else
          evt_d.press = 1'b1;
`endif
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (iEvtReady) begin
          rr_d    = (cur_chan == CH_LAST) ? '0 : cur_chan + CW'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pending bits: a new edge always wins over a same-cycle load
  always_comb begin
    pend_d = pend_q;
    drop_d = 1'b0;
    if (load) pend_d[sel] = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (evt_w[i]) begin
        if (pend_q[i] && !(load && sel == CW'(i))) drop_d = 1'b1;
        pend_d[i] = 1'b1;
      end
    end
  end

  // top-level state registers
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ps_q    <= '0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
      state_q <= ST_IDLE;
      evt_q   <= '{chan: '0, press: PRESS_RST};
      rr_q    <= '0;
    end else begin
      ps_q    <= ps_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      state_q <= state_d;
      evt_q   <= evt_d;
      rr_q    <= rr_d;
    end
  end

  assign oEvtValid = (state_q == ST_OFFER);
  assign oEvtChan  = cur_chan;
  assign oEvtPress = evt_q.press;
  assign oDrop     = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: scenario tasks plus a randomized
// toggle run checked against a per-channel event list model.
`timescale 1ns/1ps
module tb_button_event_arbiter;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int ST = 3;

`ifdef DT_RELEASE_EVENT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  typedef struct {
    int chan;
    bit press;
  } ev_s;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] btn = '0;
  logic [CH-1:0] level;
  logic          valid;
  logic          ready = 1'b0;
  logic [1:0]    chan;
  logic          press;
  logic          drop;

  int  errors = 0;
  int  checks = 0;
  int  drop_cnt = 0;
  ev_s evq[$];

  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [1:0] pc = '0;
  logic       pp = 1'b0;

  always #5 clk = ~clk;

  button_event_arbiter #(
    .CHANNELS    (CH),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iButtons (btn),
    .oLevel   (level),
    .oEvtValid(valid),
    .iEvtReady(ready),
    .oEvtChan (chan),
    .oEvtPress(press),
    .oDrop    (drop)
  );

  // handshake log, drop count and offer stability
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        checks++;
        if (valid !== 1'b1 || chan !== pc || press !== pp) begin
          errors++;
          $display("FAIL hold_stable: got v=%b c=%0d p=%b need v=1 c=%0d p=%b",
                   valid, chan, press, pc, pp);
        end
      end
      if (valid === 1'b1 && ready === 1'b1)
        evq.push_back('{int'(chan), press});
      if (drop === 1'b1) drop_cnt++;
      pv = valid;
      pr = ready;
      pc = chan;
      pp = press;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn   = '0;
    ready = 1'b0;
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    evq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn = CH'($urandom);
      cyc(1);
      checks++;
      if (level !== '0 || valid !== 1'b0 || chan !== '0 ||
          press !== !REL || drop !== 1'b0) begin
        errors++;
        $display("FAIL reset_out: lvl=%b v=%b c=%0d p=%b d=%b need 0 0 0 %b 0",
                 level, valid, chan, press, drop, !REL);
      end
    end
    btn = '0;
    @(negedge clk);
    rst_n = 1'b1;
    evq.delete();
    cyc(40);
    checks++;
    if (evq.size() !== 0 || level !== '0) begin
      errors++;
      $display("FAIL reset_idle: events=%0d lvl=%b need 0 0",
               evq.size(), level);
    end
  endtask

  task automatic test_single_press();
    int lat;
    ready = 1'b1;
    evq.delete();
    lat = -1;
    btn[2] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc(1);
      if (lat < 0 && level[2] === 1'b1) lat = n;
    end
    checks++;
    if (lat < 10 || lat > 14) begin
      errors++;
      $display("FAIL press_latency: got %0d need 10..14", lat);
    end
    cyc(5);
    checks++;
    if (evq.size() !== 1) begin
      errors++;
      $display("FAIL press_count: got %0d need 1", evq.size());
    end else if (evq[0].chan != 2 || evq[0].press != 1'b1) begin
      errors++;
      $display("FAIL press_event: got c=%0d p=%b need c=2 p=1",
               evq[0].chan, evq[0].press);
    end
    evq.delete();
    btn[2] = 1'b0;
    cyc(25);
    checks++;
    if (evq.size() !== (REL ? 1 : 0)) begin
      errors++;
      $display("FAIL release_count: got %0d need %0d", evq.size(), REL);
    end else if (REL && (evq[0].chan != 2 || evq[0].press != 1'b0)) begin
      errors++;
      $display("FAIL release_event: got c=%0d p=%b need c=2 p=0",
               evq[0].chan, evq[0].press);
    end
  endtask

  task automatic test_glitch();
    int  d0;
    bit  rose;
    d0   = drop_cnt;
    rose = 1'b0;
    evq.delete();
    ready  = 1'b1;
    btn[1] = 1'b1;
    cyc(6);
    btn[1] = 1'b0;
    for (int n = 0; n < 30; n++) begin
      cyc(1);
      if (level[1] !== 1'b0) rose = 1'b1;
    end
    checks++;
    if (rose || evq.size() !== 0 || drop_cnt !== d0) begin
      errors++;
      $display("FAIL glitch: rose=%b events=%0d drops=%0d need 0 0 0",
               rose, evq.size(), drop_cnt - d0);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    ready = 1'b1;
    btn = 4'b1001;
    cyc(25);
    checks++;
    if (evq.size() !== 2) begin
      errors++;
      $display("FAIL fair_press_count: got %0d need 2", evq.size());
    end else if (evq[0].chan != 0 || evq[1].chan != 3 ||
                 !evq[0].press || !evq[1].press) begin
      errors++;
      $display("FAIL fair_press_order: got %0d/%b %0d/%b need 0/1 3/1",
               evq[0].chan, evq[0].press, evq[1].chan, evq[1].press);
    end
    evq.delete();
    btn = '0;
    cyc(25);
    checks++;
    if (evq.size() !== (REL ? 2 : 0)) begin
      errors++;
      $display("FAIL fair_rel_count: got %0d need %0d",
               evq.size(), REL ? 2 : 0);
    end else if (REL && (evq[0].chan != 0 || evq[1].chan != 3 ||
                         evq[0].press || evq[1].press)) begin
      errors++;
      $display("FAIL fair_rel_order: got %0d/%b %0d/%b need 0/0 3/0",
               evq[0].chan, evq[0].press, evq[1].chan, evq[1].press);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    ready = 1'b0;
    evq.delete();
    d0 = drop_cnt;
    btn[0] = 1'b1;
    cyc(20);
    checks++;
    if (valid !== 1'b1 || chan !== 2'd0 || press !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall: got v=%b c=%0d p=%b need 1 0 1",
               valid, chan, press);
    end
    btn[1] = 1'b1;
    cyc(20);
    btn[1] = 1'b0;
    cyc(20);
    checks++;
    if (drop_cnt - d0 !== (REL ? 1 : 0)) begin
      errors++;
      $display("FAIL bp_drop: got %0d need %0d", drop_cnt - d0, REL);
    end
    ready = 1'b1;
    cyc(10);
    checks++;
    if (evq.size() !== 2) begin
      errors++;
      $display("FAIL bp_count: got %0d need 2", evq.size());
    end else if (evq[0].chan != 0 || !evq[0].press ||
                 evq[1].chan != 1 || evq[1].press != !REL) begin
      errors++;
      $display("FAIL bp_events: got %0d/%b %0d/%b need 0/1 1/%b",
               evq[0].chan, evq[0].press, evq[1].chan, evq[1].press, !REL);
    end
    btn[0] = 1'b0;
    cyc(25);
    evq.delete();
  endtask

  task automatic test_reset_mid_offer();
    bit seen;
    seen  = 1'b0;
    ready = 1'b0;
    btn[2] = 1'b1;
    for (int n = 0; n < 30 && !seen; n++) begin
      cyc(1);
      if (valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_offer_valid: got 0 need 1 within 30 cycles");
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    btn   = '0;
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_offer_async: got valid=%b need 0", valid);
    end
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    evq.delete();
    cyc(40);
    checks++;
    if (evq.size() !== 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_offer_stale: events=%0d v=%b need 0 0",
               evq.size(), valid);
    end
  endtask

  task automatic test_random();
    ev_s       expq[$];
    logic [CH-1:0] nb;
    int        d0;
    do_reset();
    d0 = drop_cnt;
    for (int r = 0; r < 12; r++) begin
      nb = btn ^ CH'($urandom);
      for (int c = 0; c < CH; c++)
        if (nb[c] != btn[c] && (REL || nb[c]))
          expq.push_back('{c, nb[c]});
      btn = nb;
      for (int n = 0; n < 45; n++) begin
        ready = ($urandom_range(3) != 0);
        cyc(1);
      end
      checks++;
      if (level !== btn) begin
        errors++;
        $display("FAIL rand_level: round %0d got %b need %b", r, level, btn);
      end
    end
    ready = 1'b1;
    cyc(20);
    for (int c = 0; c < CH; c++) begin
      ev_s got[$];
      ev_s want[$];
      bit  bad;
      foreach (evq[i]) if (evq[i].chan == c) got.push_back(evq[i]);
      foreach (expq[i]) if (expq[i].chan == c) want.push_back(expq[i]);
      bad = (got.size() != want.size());
      if (!bad)
        foreach (got[i]) if (got[i].press != want[i].press) bad = 1'b1;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL rand_chan%0d: got %0d events need %0d (or polarity)",
                 c, got.size(), want.size());
      end
    end
    checks++;
    if (drop_cnt !== d0) begin
      errors++;
      $display("FAIL rand_drop: got %0d need 0", drop_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_fairness();
    test_backpressure();
    test_reset_mid_offer();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
